flex_updown_counter: RTL and testbench



---
 rtl/flex_counter_pkg.sv | 13 +
 rtl/flex_counter_next.sv | 50 +++++
 rtl/flex_updown_counter.sv | 90 +++++++++
 tb/tb_flex_updown_counter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types and constants for the flex up/down counter family.
// Direction encoding matches the count_up input: 1 = increment, 0 = decrement.
package flex_counter_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fc_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/flex_counter_next.sv
// Combinational next-count for one enabled step against terminal count R.
// Also used by the PWM prescaler, so it holds no state and no enable.
module flex_counter_next
    import flex_counter_pkg::*;
#(
    parameter int NUM_BITS = 4
) (
    input  logic [NUM_BITS-1:0] count,
    input  logic [NUM_BITS-1:0] rollover_val,
    input  logic                dir,
    output logic [NUM_BITS-1:0] next_count,
    output logic                wrap
);

    localparam logic [NUM_BITS-1:0] ONE = {{(NUM_BITS-1){1'b0}}, 1'b1};

    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        if (rollover_val == '0) begin
            // R = 0 parks the counter at zero and never reports a wrap
            next_count = '0;
        end else begin
            case (dir)
                DIR_UP: begin
                    // >= rather than == so a count left above a lowered R wraps instead of overflowing
                    if (count >= rollover_val) begin
                        next_count = ONE;
                        wrap       = 1'b1;
                    end else begin
                        next_count = count + ONE;
                    end
                end
                DIR_DOWN: begin
                    if (count <= ONE) begin
                        next_count = rollover_val;
                        wrap       = 1'b1;
                    end else begin
                        next_count = count - ONE;
                    end
                end
                default: begin
                    next_count = count;
                    wrap       = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/flex_updown_counter.sv
// NUM_BITS up/down counter with clear, load, programmable rollover and wrap pulse.
// Define FLEX_COUNTER_ONESHOT_EN to add the oneshot input and done output (stop at terminal).
module flex_updown_counter
    import flex_counter_pkg::*;
#(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic                count_up,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_val,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag,
    output logic                wrap_pulse
`ifdef FLEX_COUNTER_ONESHOT_EN
    ,
    input  logic                oneshot,
    output logic                done
`endif
);

    localparam logic [NUM_BITS-1:0] ONE = {{(NUM_BITS-1){1'b0}}, 1'b1};

    fc_state_t             state;
    fc_state_t             state_d;
    logic [NUM_BITS-1:0]   step_count;
    logic                  step_wrap;
    logic [NUM_BITS-1:0]   count_d;
    logic                  wrap_d;
    logic                  oneshot_mode;

`ifdef FLEX_COUNTER_ONESHOT_EN
    assign oneshot_mode = oneshot;
    assign done         = (state == HALT);
`else
    assign oneshot_mode = 1'b0;
`endif

    flex_counter_next #(
        .NUM_BITS(NUM_BITS)
    ) u_next (
        .count       (count_out),
        .rollover_val(rollover_val),
        .dir         (count_up),
        .next_count  (step_count),
        .wrap        (step_wrap)
    );

    // Priority: clear > load > enabled step; HALT ignores count_enable
    always_comb begin
        count_d = count_out;
        wrap_d  = 1'b0;
        state_d = state;
        if (clear) begin
            count_d = '0;
            state_d = RUN;
        end else if (load) begin
            count_d = load_val;
            state_d = RUN;
        end else if (count_enable && (state == RUN)) begin
            if (step_wrap && oneshot_mode) begin
                count_d = (count_up == DIR_UP) ? rollover_val : ONE;
                state_d = HALT;
            end else begin
                count_d = step_count;
                wrap_d  = step_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            wrap_pulse    <= 1'b0;
            state         <= RUN;
        end else begin
            count_out     <= count_d;
            // Flag tracks the value being registered against the R seen at this edge
            rollover_flag <= (count_d == rollover_val) && (rollover_val != '0);
            wrap_pulse    <= wrap_d;
            state         <= state_d;
        end
    end

endmodule

// File: tb/tb_flex_updown_counter.sv
// Randomised and directed bench for flex_updown_counter against an arithmetic reference model.
module tb_flex_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         clear;
  logic         count_enable;
  logic         count_up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] rollover_val;
  logic [W-1:0] count_out;
  logic         rollover_flag;
  logic         wrap_pulse;
`ifdef FLEX_COUNTER_ONESHOT_EN
  logic         oneshot;
  logic         done;
`endif

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_count = 0;
  int m_flag  = 0;
  int m_wrap  = 0;
  int m_halt  = 0;
  int m_r;
  int m_os;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  flex_updown_counter #(.NUM_BITS(W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .count_up     (count_up),
    .load         (load),
    .load_val     (load_val),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse)
`ifdef FLEX_COUNTER_ONESHOT_EN
    ,
    .oneshot      (oneshot),
    .done         (done)
`endif
  );

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model: evaluated from the inputs present at each rising edge
  always @(posedge clk) begin
    m_r = int'(rollover_val);
`ifdef FLEX_COUNTER_ONESHOT_EN
    m_os = int'(oneshot);
`else
    m_os = 0;
`endif
    m_wrap = 0;
    if (!n_rst || clear) begin
      m_count = 0;
      m_halt  = 0;
    end else if (load) begin
      m_count = int'(load_val);
      m_halt  = 0;
    end else if (count_enable && m_halt == 0) begin
      if (m_r == 0) begin
        m_count = 0;
      end else if (count_up) begin
        if (m_count < m_r) m_count = m_count + 1;
        else if (m_os != 0) begin m_count = m_r; m_halt = 1; end
        else begin m_count = 1; m_wrap = 1; end
      end else begin
        if (m_count > 1) m_count = m_count - 1;
        else if (m_os != 0) begin m_count = 1; m_halt = 1; end
        else begin m_count = m_r; m_wrap = 1; end
      end
    end
    m_flag   = (m_count == m_r && m_r != 0) ? 1 : 0;
    check_en = 1'b1;
  end

  // scoreboard compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_count", int'(count_out), m_count);
      chk("model_flag", int'(rollover_flag), m_flag);
      chk("model_wrap", int'(wrap_pulse), m_wrap);
`ifdef FLEX_COUNTER_ONESHOT_EN
      chk("model_done", int'(done), m_halt);
`endif
    end
  end

  initial begin
    int exp;
    int dn_exp[5];
    dn_exp = '{2, 1, 5, 4, 3};

    n_rst = 1'b0; clear = 1'b0; count_enable = 1'b0; count_up = 1'b1;
    load = 1'b0; load_val = '0; rollover_val = 4'd12;
`ifdef FLEX_COUNTER_ONESHOT_EN
    oneshot = 1'b0;
`endif
    tick(); tick();
    chk("reset_count", int'(count_out), 0);
    chk("reset_flag", int'(rollover_flag), 0);
    chk("reset_wrap", int'(wrap_pulse), 0);

    // up count R=12 for 15 cycles
    n_rst = 1'b1; count_enable = 1'b1; count_up = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp = (i <= 12) ? i : i - 12;
      chk("up_count", int'(count_out), exp);
      chk("up_flag", int'(rollover_flag), (exp == 12) ? 1 : 0);
      chk("up_wrap", int'(wrap_pulse), (i == 13) ? 1 : 0);
    end

    // load 3, count down with R=5
    count_enable = 1'b0; load = 1'b1; load_val = 4'd3; rollover_val = 4'd5;
    tick();
    chk("load3_count", int'(count_out), 3);
    load = 1'b0; count_up = 1'b0; count_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("down_count", int'(count_out), dn_exp[i]);
      chk("down_wrap", int'(wrap_pulse), (i == 2) ? 1 : 0);
      chk("down_flag", int'(rollover_flag), (dn_exp[i] == 5) ? 1 : 0);
    end

    // clear beats load and enable
    clear = 1'b1; load = 1'b1; load_val = 4'd9; count_enable = 1'b1;
    tick();
    chk("clr_pri_count", int'(count_out), 0);
    chk("clr_pri_flag", int'(rollover_flag), 0);
    chk("clr_pri_wrap", int'(wrap_pulse), 0);
    clear = 1'b0; count_enable = 1'b0;
    tick();
    chk("load9_count", int'(count_out), 9);

    // R lowered below the count, then R = 0
    load_val = 4'd10; rollover_val = 4'd12;
    tick();
    chk("load10_count", int'(count_out), 10);
    load = 1'b0; rollover_val = 4'd6; count_enable = 1'b1; count_up = 1'b1;
    tick();
    chk("rdrop_count", int'(count_out), 1);
    chk("rdrop_wrap", int'(wrap_pulse), 1);
    rollover_val = 4'd0;
    tick();
    chk("r0_count", int'(count_out), 0);
    chk("r0_flag", int'(rollover_flag), 0);
    chk("r0_wrap", int'(wrap_pulse), 0);

    // reset mid-count at 7
    count_enable = 1'b0; clear = 1'b1; rollover_val = 4'd12;
    tick();
    clear = 1'b0; count_enable = 1'b1;
    repeat (7) tick();
    chk("pre_rst_count", int'(count_out), 7);
    n_rst = 1'b0;
    tick();
    chk("mid_rst_count", int'(count_out), 0);
    chk("mid_rst_flag", int'(rollover_flag), 0);
    chk("mid_rst_wrap", int'(wrap_pulse), 0);
    n_rst = 1'b1;
    tick();
    chk("resume1_count", int'(count_out), 1);
    tick();
    chk("resume2_count", int'(count_out), 2);

`ifdef FLEX_COUNTER_ONESHOT_EN
    // one-shot up to R=4
    count_enable = 1'b0; clear = 1'b1; rollover_val = 4'd4; oneshot = 1'b1;
    tick();
    clear = 1'b0; count_enable = 1'b1; count_up = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("os_count", int'(count_out), (i < 4) ? i : 4);
      chk("os_done", int'(done), (i >= 5) ? 1 : 0);
      chk("os_wrap", int'(wrap_pulse), 0);
    end
    count_enable = 1'b0; load = 1'b1; load_val = 4'd0;
    tick();
    chk("os_load_done", int'(done), 0);
    chk("os_load_count", int'(count_out), 0);
    load = 1'b0; count_enable = 1'b1;
    tick();
    chk("os_resume_count", int'(count_out), 1);
    oneshot = 1'b0;
`endif

    // randomised traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      n_rst        = ($urandom_range(0, 99) != 0);
      clear        = ($urandom_range(0, 49) == 0);
      load         = ($urandom_range(0, 19) == 0);
      count_enable = ($urandom_range(0, 3) != 0);
      load_val     = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 15) == 0) count_up = ~count_up;
      if ($urandom_range(0, 31) == 0)
        rollover_val = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 3))
                                                   : W'($urandom_range(0, (1 << W) - 1));
`ifdef FLEX_COUNTER_ONESHOT_EN
      if ($urandom_range(0, 63) == 0) oneshot = ~oneshot;
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
